// File: rtl/digit_ctrl_pkg.sv
// Shared types and constants for the digit entry lock controller.
package digit_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKOUT
    } state_t;

    localparam logic [7:0] DEFAULT_CODE = 8'h79;
    localparam int unsigned TRIES_W = 4;

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector: registered one-cycle press pulse per 0->1 transition.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;

    // History resets high so a button held through reset release is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b1;
            press <= 1'b0;
        end else begin
            prev  <= btn;
            press <= btn & ~prev;
        end
    end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Digit entry lock controller: sequences digit counters, checks code, handles open/fail/lockout.
// Optional ENTRY inactivity timeout enabled by defining DIGIT_ENTRY_CTRL_TIMEOUT_EN.
module digit_entry_ctrl
    import digit_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIGIT_W        = 2,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE = DEFAULT_CODE,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned OPEN_CYCLES    = 100_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 300_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            btn_inc,
    input  logic                            btn_next,
    input  logic                            btn_enter,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
    output logic [NUM_DIGITS-1:0]           inc,
    output logic                            clr_all,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_sel,
    output logic                            unlock,
    output logic                            fail,
    output logic                            alarm,
    output logic [TRIES_W-1:0]              tries
);

    localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
    localparam logic [31:0] OPEN_LOAD = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] LOCK_LOAD = 32'(LOCKOUT_CYCLES - 1);
`ifdef DIGIT_ENTRY_CTRL_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
`endif

    logic inc_p, next_p, enter_p, any_press;

    btn_edge_det u_edge_inc   (.clk(clk), .rst(rst), .btn(btn_inc),   .press(inc_p));
    btn_edge_det u_edge_next  (.clk(clk), .rst(rst), .btn(btn_next),  .press(next_p));
    btn_edge_det u_edge_enter (.clk(clk), .rst(rst), .btn(btn_enter), .press(enter_p));

    assign any_press = inc_p | next_p | enter_p;

    state_t                 state, state_n;
    logic [31:0]            timer, timer_n;
    logic [SEL_W-1:0]       sel_n;
    logic [TRIES_W-1:0]     tries_n;
    logic [NUM_DIGITS-1:0]  inc_n;
    logic                   clr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            digit_sel <= '0;
            tries     <= '0;
            inc       <= '0;
            clr_all   <= 1'b0;
            unlock    <= 1'b0;
            fail      <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            digit_sel <= sel_n;
            tries     <= tries_n;
            inc       <= inc_n;
            clr_all   <= clr_n;
            unlock    <= (state_n == ST_OPEN);
            fail      <= (state_n == ST_FAIL);
            alarm     <= (state_n == ST_LOCKOUT);
        end
    end

    // Registered outputs are decoded from the next state so they align with the state they belong to.
    always_comb begin
        state_n = state;
        timer_n = timer;
        sel_n   = digit_sel;
        tries_n = tries;
        inc_n   = '0;
        clr_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_press) begin
                    state_n = ST_ENTRY;
                    clr_n   = 1'b1;
                    sel_n   = '0;
`ifdef DIGIT_ENTRY_CTRL_TIMEOUT_EN
                    timer_n = TIMEOUT_LOAD;
`endif
                end
            end
            ST_ENTRY: begin
                if (enter_p) begin
                    state_n = ST_CHECK;
                end else if (next_p) begin
                    if (digit_sel == SEL_W'(NUM_DIGITS - 1))
                        sel_n = '0;
                    else
                        sel_n = digit_sel + 1'b1;
                end else if (inc_p) begin
                    inc_n = NUM_DIGITS'(1) << digit_sel;
                end
`ifdef DIGIT_ENTRY_CTRL_TIMEOUT_EN
                if (any_press) begin
                    timer_n = TIMEOUT_LOAD;
                end else if (timer == '0) begin
                    state_n = ST_IDLE;
                    clr_n   = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
`endif
            end
            ST_CHECK: begin
                if (digits_in == CODE) begin
                    state_n = ST_OPEN;
                    tries_n = '0;
                    timer_n = OPEN_LOAD;
                end else begin
                    tries_n = tries + 1'b1;
                    if (tries_n == TRIES_W'(MAX_TRIES)) begin
                        state_n = ST_LOCKOUT;
                        timer_n = LOCK_LOAD;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end
            end
            ST_OPEN: begin
                if (enter_p || timer == '0) begin
                    state_n = ST_IDLE;
                    clr_n   = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            ST_FAIL: begin
                state_n = ST_ENTRY;
                clr_n   = 1'b1;
                sel_n   = '0;
`ifdef DIGIT_ENTRY_CTRL_TIMEOUT_EN
                timer_n = TIMEOUT_LOAD;
`endif
            end
            ST_LOCKOUT: begin
                if (timer == '0) begin
                    state_n = ST_IDLE;
                    tries_n = '0;
                    clr_n   = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
